// File: rtl/video_timing_pal_pipe_if.sv
// Video output stage bus: PPU pixel inputs, crop/border configuration, palette ROM port
// and the aligned RGB/sync/blank outputs.
interface video_timing_pal_pipe_if #(
    parameter int PAL_AW = 10
);
    logic [5:0]        color;
    logic [3:0]        palette;
    logic [8:0]        count_v;
    logic              pal_video;
    logic              ovs_en;
    logic [4:0]        ovs_left;
    logic [4:0]        ovs_right;
    logic [3:0]        ovs_top;
    logic [3:0]        ovs_bot;
    logic [23:0]       border_rgb;
    logic [PAL_AW-1:0] pal_addr;
    logic [23:0]       pal_data;
    logic [7:0]        r;
    logic [7:0]        g;
    logic [7:0]        b;
    logic              sync_h;
    logic              sync_v;
    logic              hblank;
    logic              vblank;
    logic              de;
    logic              ce_pix;
    logic [15:0]       frame_cnt;
    logic              locked;

    modport slave (
        input  color, palette, count_v, pal_video, ovs_en, ovs_left, ovs_right,
               ovs_top, ovs_bot, border_rgb, pal_data,
        output pal_addr, r, g, b, sync_h, sync_v, hblank, vblank, de, ce_pix,
               frame_cnt, locked
    );

    modport master (
        output color, palette, count_v, pal_video, ovs_en, ovs_left, ovs_right,
               ovs_top, ovs_bot, border_rgb, pal_data,
        input  pal_addr, r, g, b, sync_h, sync_v, hblank, vblank, de, ce_pix,
               frame_cnt, locked
    );
endinterface

// File: rtl/video_timing_pal_pipe.sv
// Raster timing generator with PPU frame resync, palette ROM lookup, overscan crop and a
// two-stage output pipeline that keeps colour, sync and blanking mutually aligned.
module video_timing_pal_pipe #(
    parameter int CLK_DIV    = 2,
    parameter int H_ACTIVE   = 512,
    parameter int H_TOTAL    = 682,
    parameter int HS_START   = 556,
    parameter int HS_END     = 606,
    parameter int V_ACTIVE   = 240,
    parameter int V_TOTAL_N  = 262,
    parameter int V_TOTAL_P  = 312,
    parameter int VS_START_N = 243,
    parameter int VS_START_P = 270,
    parameter int VS_LEN     = 3,
    parameter bit SYNC_NEG   = 1'b0,
    parameter int PAL_AW     = 10
) (
    input logic                    clk,
    input logic                    reset_n,
    video_timing_pal_pipe_if.slave vif
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef struct packed {
        logic        hpic;
        logic        vpic;
        logic        crop;
        logic        hs;
        logic        vs;
        logic        lk;
        logic [15:0] fc;
        logic [23:0] border;
    } stage_t;

    logic [DW-1:0]     div;
    logic              ce;
    logic [9:0]        h, v;
    logic [8:0]        cv_prev;
    logic              vs_lat;
    logic [15:0]       frame_cnt;
    logic              locked;
    logic [PAL_AW-1:0] pal_addr_q;
    stage_t            s1, s2;
    logic [2:1]        vld_pipe;

    logic [9:0]  v_last, vs_start;
    logic [10:0] vs_end;
    logic        h_wrap, v_wrap, resync, v_in_vs, crop_now;

    assign v_last   = vif.pal_video ? 10'(V_TOTAL_P - 1) : 10'(V_TOTAL_N - 1);
    assign vs_start = vif.pal_video ? 10'(VS_START_P) : 10'(VS_START_N);
    assign vs_end   = {1'b0, vs_start} + 11'(VS_LEN);
    assign h_wrap   = (h == 10'(H_TOTAL - 1));
    assign v_wrap   = h_wrap && (v == v_last);
    assign resync   = ce && (cv_prev == 9'd511) && (vif.count_v == 9'd0);
    assign v_in_vs  = (v >= vs_start) && ({1'b0, v} < vs_end);
    assign crop_now = vif.ovs_en && ((h < 10'(vif.ovs_left)) ||
                                     (h >= 10'(H_ACTIVE) - 10'(vif.ovs_right)) ||
                                     (v < 10'(vif.ovs_top)) ||
                                     (v >= 10'(V_ACTIVE) - 10'(vif.ovs_bot)));

    // ce is registered so the first pixel enable lands CLK_DIV clocks after reset release
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div <= '0;
            ce  <= 1'b0;
        end else begin
            ce  <= (div == DW'(CLK_DIV - 1));
            div <= (div == DW'(CLK_DIV - 1)) ? '0 : div + DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            h         <= '0;
            v         <= '0;
            cv_prev   <= '0;
            frame_cnt <= '0;
            locked    <= 1'b0;
        end else if (ce) begin
            cv_prev <= vif.count_v;
            if (resync) begin
                h         <= '0;
                v         <= '0;
                locked    <= v_wrap;
                frame_cnt <= frame_cnt + 16'd1;
            end else if (h_wrap) begin
                h <= '0;
                if (v == v_last) begin
                    v         <= '0;
                    frame_cnt <= frame_cnt + 16'd1;
                end else begin
                    v <= v + 10'd1;
                end
            end else begin
                h <= h + 10'd1;
            end
        end
    end

    // vsync is sampled once per line at the hsync leading edge
    always_ff @(posedge clk) begin
        if (!reset_n)
            vs_lat <= 1'b0;
        else if (h == 10'(HS_START))
            vs_lat <= v_in_vs;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pal_addr_q <= '0;
            s1         <= '0;
            s2         <= '0;
            vld_pipe   <= '0;
        end else begin
            pal_addr_q <= PAL_AW'({vif.palette, vif.color});
            s1.hpic    <= (h < 10'(H_ACTIVE));
            s1.vpic    <= (v < 10'(V_ACTIVE));
            s1.crop    <= crop_now;
            s1.hs      <= (h >= 10'(HS_START)) && (h < 10'(HS_END));
            s1.vs      <= (h == 10'(HS_START)) ? v_in_vs : vs_lat;
            s1.lk      <= locked;
            s1.fc      <= frame_cnt;
            s1.border  <= vif.border_rgb;
            s2         <= s1;
            vld_pipe   <= {vld_pipe[1], ce};
        end
    end

    // ROM data arrives in the same cycle as the S2 flags, so the final colour mux is combinational
    logic [23:0] rgb;
    assign rgb = !(s2.hpic && s2.vpic) ? 24'h0 : (s2.crop ? s2.border : vif.pal_data);

    assign vif.pal_addr  = pal_addr_q;
    assign vif.r         = rgb[23:16];
    assign vif.g         = rgb[15:8];
    assign vif.b         = rgb[7:0];
    assign vif.sync_h    = s2.hs ^ SYNC_NEG;
    assign vif.sync_v    = s2.vs ^ SYNC_NEG;
    assign vif.hblank    = !s2.hpic;
    assign vif.vblank    = !s2.vpic;
    assign vif.de        = s2.hpic && s2.vpic;
    assign vif.ce_pix    = vld_pipe[2];
    assign vif.frame_cnt = s2.fc;
    assign vif.locked    = s2.lk;
endmodule

// File: tb/tb_video_timing_pal_pipe.sv
// Scoreboard bench: a raster reference model queues the expected output of every pixel
// enable; monitors on a positive- and a negative-sync instance pop and compare on ce_pix.
module tb_video_timing_pal_pipe;
    localparam int CD  = 2;
    localparam int HA  = 40;
    localparam int HT  = 52;
    localparam int HSS = 44;
    localparam int HSE = 48;
    localparam int VA  = 12;
    localparam int VTN = 16;
    localparam int VTP = 19;
    localparam int VSN = 13;
    localparam int VSP = 15;
    localparam int VSL = 3;

    typedef struct packed {
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic        de;
        logic [15:0] fc;
        logic        lk;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic [5:0]  color;
    logic [3:0]  palette;
    logic [8:0]  count_v;
    logic        pal_video;
    logic        ovs_en;
    logic [4:0]  ovs_left, ovs_right;
    logic [3:0]  ovs_top, ovs_bot;
    logic [23:0] border_rgb;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b1;

    int mh, mv, mdiv, mcvp, mfc;
    bit mce, mvsl, mlk;

    video_timing_pal_pipe_if #(.PAL_AW(10)) ifa ();
    video_timing_pal_pipe_if #(.PAL_AW(10)) ifb ();

    video_timing_pal_pipe #(
        .CLK_DIV(CD), .H_ACTIVE(HA), .H_TOTAL(HT), .HS_START(HSS), .HS_END(HSE),
        .V_ACTIVE(VA), .V_TOTAL_N(VTN), .V_TOTAL_P(VTP), .VS_START_N(VSN),
        .VS_START_P(VSP), .VS_LEN(VSL), .SYNC_NEG(1'b0), .PAL_AW(10)
    ) dut_a (.clk(clk), .reset_n(reset_n), .vif(ifa));

    video_timing_pal_pipe #(
        .CLK_DIV(CD), .H_ACTIVE(HA), .H_TOTAL(HT), .HS_START(HSS), .HS_END(HSE),
        .V_ACTIVE(VA), .V_TOTAL_N(VTN), .V_TOTAL_P(VTP), .VS_START_N(VSN),
        .VS_START_P(VSP), .VS_LEN(VSL), .SYNC_NEG(1'b1), .PAL_AW(10)
    ) dut_b (.clk(clk), .reset_n(reset_n), .vif(ifb));

    assign ifa.color = color;           assign ifb.color = color;
    assign ifa.palette = palette;       assign ifb.palette = palette;
    assign ifa.count_v = count_v;       assign ifb.count_v = count_v;
    assign ifa.pal_video = pal_video;   assign ifb.pal_video = pal_video;
    assign ifa.ovs_en = ovs_en;         assign ifb.ovs_en = ovs_en;
    assign ifa.ovs_left = ovs_left;     assign ifb.ovs_left = ovs_left;
    assign ifa.ovs_right = ovs_right;   assign ifb.ovs_right = ovs_right;
    assign ifa.ovs_top = ovs_top;       assign ifb.ovs_top = ovs_top;
    assign ifa.ovs_bot = ovs_bot;       assign ifb.ovs_bot = ovs_bot;
    assign ifa.border_rgb = border_rgb; assign ifb.border_rgb = border_rgb;

    function automatic logic [23:0] rom(input logic [9:0] a);
        if (a == 10'h0E1) return 24'h123456;
        return {a[7:0], ~a[7:0], 6'd0, a[9:8]};
    endfunction

    // synchronous palette ROM: data one clock after the address
    always @(posedge clk) begin
        ifa.pal_data <= rom(ifa.pal_addr);
        ifb.pal_data <= rom(ifb.pal_addr);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic sb_cmp(input string nm, input exp_t act, input exp_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got rgb=%h hs=%b vs=%b hb=%b vb=%b de=%b fc=%0d lk=%b expected rgb=%h hs=%b vs=%b hb=%b vb=%b de=%b fc=%0d lk=%b (model h=%0d v=%0d)",
                     nm, {act.r, act.g, act.b}, act.hs, act.vs, act.hb, act.vb, act.de, act.fc, act.lk,
                     {exp.r, exp.g, exp.b}, exp.hs, exp.vs, exp.hb, exp.vb, exp.de, exp.fc, exp.lk, mh, mv);
        end
    endtask

    // reference raster model, advanced once per clock with the inputs the DUT is about to sample
    task automatic step();
        exp_t e;
        int   vt, vss;
        bit   vr, resy, hp, vp, crop;
        if (!reset_n) begin
            mh = 0; mv = 0; mdiv = 0; mcvp = 0; mfc = 0;
            mce = 0; mvsl = 0; mlk = 0;
            qa.delete();
            qb.delete();
            return;
        end
        vt  = pal_video ? VTP : VTN;
        vss = pal_video ? VSP : VSN;
        vr  = (mv >= vss) && (mv < vss + VSL);
        if (mce) begin
            hp   = (mh < HA);
            vp   = (mv < VA);
            crop = ovs_en && ((mh < int'(ovs_left)) || (mh >= HA - int'(ovs_right)) ||
                              (mv < int'(ovs_top)) || (mv >= VA - int'(ovs_bot)));
            e.de = hp && vp;
            e.hb = !hp;
            e.vb = !vp;
            e.hs = (mh >= HSS) && (mh < HSE);
            e.vs = (mh == HSS) ? vr : mvsl;
            {e.r, e.g, e.b} = !e.de ? 24'h0 : (crop ? border_rgb : rom({palette, color}));
            e.fc = 16'(mfc);
            e.lk = mlk;
            qa.push_back(e);
            qb.push_back(e);
            if (mh == HSS) mvsl = vr;
            resy = (mcvp == 511) && (count_v == 9'd0);
            mcvp = int'(count_v);
            if (resy) begin
                mlk = (mh == HT - 1) && (mv == vt - 1);
                mh = 0; mv = 0;
                mfc = (mfc + 1) & 16'hFFFF;
            end else if (mh == HT - 1) begin
                mh = 0;
                if (mv == vt - 1) begin
                    mv = 0;
                    mfc = (mfc + 1) & 16'hFFFF;
                end else begin
                    mv = mv + 1;
                end
            end else begin
                mh = mh + 1;
            end
        end
        mce  = (mdiv == CD - 1);
        mdiv = (mdiv == CD - 1) ? 0 : mdiv + 1;
    endtask

    task automatic cyc();
        step();
        @(negedge clk);
    endtask

    task automatic wait_px(input int h, input int v);
        int n;
        n = 0;
        while (!(mce && mh == h && mv == v)) begin
            cyc();
            n++;
            if (n > 6000) begin
                checks++; errors++;
                $display("FAIL wait_px: pixel (%0d,%0d) not reached, got (%0d,%0d) expected (%0d,%0d)",
                         h, v, mh, mv, h, v);
                return;
            end
        end
    endtask

    task automatic wait_ce();
        int n;
        n = 0;
        while (!mce) begin
            cyc();
            n++;
            if (n > 2 * CD) begin
                checks++; errors++;
                $display("FAIL wait_ce: no pixel enable within %0d clocks, got 0 expected 1", 2 * CD);
                return;
            end
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_rgb"}, {8'h0, ifa.r, ifa.g, ifa.b}, 32'h0);
        chk({tag, "_hblank"}, 32'(ifa.hblank), 32'd1);
        chk({tag, "_vblank"}, 32'(ifa.vblank), 32'd1);
        chk({tag, "_de"}, 32'(ifa.de), 32'd0);
        chk({tag, "_ce_pix"}, 32'(ifa.ce_pix), 32'd0);
        chk({tag, "_sync_h_pos"}, 32'(ifa.sync_h), 32'd0);
        chk({tag, "_sync_v_pos"}, 32'(ifa.sync_v), 32'd0);
        chk({tag, "_sync_h_neg"}, 32'(ifb.sync_h), 32'd1);
        chk({tag, "_sync_v_neg"}, 32'(ifb.sync_v), 32'd1);
        chk({tag, "_pal_addr"}, 32'(ifa.pal_addr), 32'd0);
        chk({tag, "_frame_cnt"}, 32'(ifa.frame_cnt), 32'd0);
        chk({tag, "_locked"}, 32'(ifa.locked), 32'd0);
    endtask

    initial begin : mon_a
        exp_t a, e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && ifa.ce_pix === 1'b1) begin
                a.r = ifa.r; a.g = ifa.g; a.b = ifa.b;
                a.hs = ifa.sync_h; a.vs = ifa.sync_v;
                a.hb = ifa.hblank; a.vb = ifa.vblank; a.de = ifa.de;
                a.fc = ifa.frame_cnt; a.lk = ifa.locked;
                if (qa.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_pos: got pixel rgb=%h with no expected entry, expected none", {a.r, a.g, a.b});
                end else begin
                    e = qa.pop_front();
                    sb_cmp("sb_pos", a, e);
                end
            end
        end
    end

    initial begin : mon_b
        exp_t a, e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && ifb.ce_pix === 1'b1) begin
                a.r = ifb.r; a.g = ifb.g; a.b = ifb.b;
                a.hs = ~ifb.sync_h; a.vs = ~ifb.sync_v;
                a.hb = ifb.hblank; a.vb = ifb.vblank; a.de = ifb.de;
                a.fc = ifb.frame_cnt; a.lk = ifb.locked;
                if (qb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_neg: got pixel rgb=%h with no expected entry, expected none", {a.r, a.g, a.b});
                end else begin
                    e = qb.pop_front();
                    sb_cmp("sb_neg", a, e);
                end
            end
        end
    end

    initial begin : stim
        int fc0;
        reset_n = 1'b0; color = 6'h21; palette = 4'd3; count_v = 9'd7; pal_video = 1'b0;
        ovs_en = 1'b0; ovs_left = '0; ovs_right = '0; ovs_top = '0; ovs_bot = '0;
        border_rgb = 24'h0;
        @(negedge clk);
        repeat (3) cyc();
        check_reset("rst");
        reset_n = 1'b1;

        // one NTSC frame is HT*VTN pixel enables, two clocks each
        repeat (2 * HT * VTN + 10) cyc();
        chk("ntsc_frame_cnt", 32'(ifa.frame_cnt), 32'd1);
        chk("pal_addr", 32'(ifa.pal_addr), 32'h0E1);
        wait_px(5, 3); cyc(); cyc();
        chk("pal_rgb", {8'h0, ifa.r, ifa.g, ifa.b}, 32'h123456);

        repeat (2 * HT * VTN) begin
            color = 6'($urandom_range(0, 63));
            palette = 4'($urandom_range(0, 15));
            cyc();
        end
        color = 6'h21; palette = 4'd3;

        ovs_en = 1'b1; ovs_left = 5'd20; ovs_right = 5'd4; ovs_top = 4'd6; ovs_bot = 4'd2;
        border_rgb = 24'h00FF00;
        wait_px(19, 7); cyc(); cyc();
        chk("ovs_left_edge", {8'h0, ifa.r, ifa.g, ifa.b}, 32'h00FF00);
        wait_px(20, 7); cyc(); cyc();
        chk("ovs_left_in", {8'h0, ifa.r, ifa.g, ifa.b}, 32'h123456);
        wait_px(30, 5); cyc(); cyc();
        chk("ovs_top", {8'h0, ifa.r, ifa.g, ifa.b}, 32'h00FF00);
        wait_px(36, 8); cyc(); cyc();
        chk("ovs_right", {8'h0, ifa.r, ifa.g, ifa.b}, 32'h00FF00);
        wait_px(30, 10); cyc(); cyc();
        chk("ovs_bot", {8'h0, ifa.r, ifa.g, ifa.b}, 32'h00FF00);
        repeat (600) begin
            color = 6'($urandom_range(0, 63));
            cyc();
        end
        ovs_en = 1'b0; color = 6'h21;

        pal_video = 1'b1;
        wait_px(0, 0);
        wait_px(HSS, VSP); cyc(); cyc();
        chk("pal_vs_on_pos", 32'(ifa.sync_v), 32'd1);
        chk("pal_vs_on_neg", 32'(ifb.sync_v), 32'd0);
        chk("pal_hs_on_neg", 32'(ifb.sync_h), 32'd0);
        wait_px(HSS, VSP + VSL); cyc(); cyc();
        chk("pal_vs_off", 32'(ifa.sync_v), 32'd0);
        wait_px(HSS, VTP - 1); cyc(); cyc();
        chk("pal_last_line", 32'(ifa.vblank), 32'd1);
        wait_px(0, 0);
        pal_video = 1'b0;
        wait_px(0, 0);

        fc0 = mfc;
        wait_px(HT - 2, VTN - 1);
        count_v = 9'd511; cyc();
        wait_ce(); count_v = 9'd0; cyc(); count_v = 9'd7;
        repeat (3) cyc();
        chk("resync_aligned_lock", 32'(ifa.locked), 32'd1);
        chk("resync_aligned_fc", 32'(ifa.frame_cnt), 32'(fc0 + 1));

        wait_px(9, 5);
        count_v = 9'd511; cyc();
        wait_ce(); count_v = 9'd0; cyc(); count_v = 9'd7;
        repeat (3) cyc();
        chk("resync_mis_lock", 32'(ifa.locked), 32'd0);
        chk("resync_mis_fc", 32'(ifa.frame_cnt), 32'(fc0 + 2));
        chk("resync_mis_h0", 32'({ifa.hblank, ifa.vblank}), 32'd0);
        repeat (200) cyc();

        wait_px(12, 3);
        reset_n = 1'b0; cyc();
        check_reset("mid");
        reset_n = 1'b1;
        repeat (3) cyc();
        chk("restart_ce_idle", 32'(ifa.ce_pix), 32'd0);
        cyc();
        chk("restart_ce", 32'(ifa.ce_pix), 32'd1);
        chk("restart_hblank", 32'(ifa.hblank), 32'd0);
        repeat (400) cyc();

        mon_en = 1'b0;
        chk("sb_pos_pending", 32'(qa.size() <= 1), 32'd1);
        chk("sb_neg_pending", 32'(qb.size() <= 1), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
